// File: rtl/ssram_ctrl_pkg.sv
// Shared types and timing constants for the SSRAM request-side controller.
package ssram_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_CLK, RD_SETUP, RD_CLK, RD_WAIT, RECOVER
    } state_e;

    localparam int RD_EVAL_CYCLES  = 10;
    localparam int RECOVER_CYCLES  = 2;
    localparam int CLK_HIGH_CYCLES = 2;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int ENW = 5;
    localparam int WCW = 6;
    localparam int WLW = 1 << AW;
endpackage

// File: rtl/ssram_wl_dec.sv
// Registered address-to-wordline one-hot decoder, loaded when a request is granted.
module ssram_wl_dec
    import ssram_ctrl_pkg::*;
(
    input  logic           CLK_RBL,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic [AW-1:0]  addr_i,
    output logic [WLW-1:0] wl_o
);
    logic [WLW-1:0] wl_q;

    always_ff @(posedge CLK_RBL or negedge rst_n) begin
        if (!rst_n)      wl_q <= '0;
        else if (load_i) wl_q <= WLW'(1) << addr_i;
    end

    assign wl_o = wl_q;
endmodule

// File: rtl/ssram_ctrl.sv
// Sequences single-word reads/writes into the SSRAM macro strobes, waits out the
// read evaluation window and retries flagged reads with boosted discharge.
module ssram_ctrl
    import ssram_ctrl_pkg::*;
#(
    parameter int MAX_RETRY = 2
) (
    input  logic            CLK_RBL,
    input  logic            rst_n,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            gnt_o,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    input  logic [ENW-1:0]  cfg_en_i,
    input  logic [ENW-1:0]  cfg_en_boost_i,
    input  logic            cfg_mode_i,
    output logic            sram_cen_o,
    output logic            sram_wen_o,
    output logic            sram_clk_o,
    output logic [AW-1:0]   sram_brs_o,
    output logic [WLW-1:0]  sram_wl_o,
    output logic [11:0]     sram_en_o,
    output logic            sram_mode_o,
    output logic            sram_boost_en_o,
    output logic [DW-1:0]   sram_d_o,
    input  logic [DW-1:0]   sram_q_i,
    input  logic            sram_flag_i
);
    localparam logic [1:0] CLK_LAST = 2'(CLK_HIGH_CYCLES - 1);
    localparam logic [1:0] REC_LAST = 2'(RECOVER_CYCLES - 1);
    localparam logic [2:0] MAXR     = 3'(MAX_RETRY);

    state_e         state_q, state_d;
    logic           we_q, we_d, mode_q, mode_d, boost_q, boost_d, flag_q, flag_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d, qs_q, qs_d, rdata_q, rdata_d;
    logic [ENW-1:0] act_q, act_d;
    logic [2:0]     retry_q, retry_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [1:0]     ph_q, ph_d;
    logic           rvalid_q, rvalid_d, err_q, err_d;
    logic           cen_q, wen_q, clk_q;
    logic [AW-1:0]  brs_q;
    logic [ENW-1:0] en_q;
    logic [DW-1:0]  d_q;
    logic           grant;

    assign grant = req_i && (state_q == IDLE);
    assign gnt_o = grant;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        act_d    = act_q;
        mode_d   = mode_q;
        retry_d  = retry_q;
        wait_d   = wait_q;
        ph_d     = ph_q;
        boost_d  = boost_q;
        qs_d     = qs_q;
        flag_d   = flag_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                boost_d = 1'b0;
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    act_d   = cfg_en_i;
                    mode_d  = cfg_mode_i;
                    retry_d = '0;
                    state_d = we_i ? WR_SETUP : RD_SETUP;
                end
            end
            WR_SETUP: state_d = WR_CLK;
            WR_CLK: begin
                ph_d    = '0;
                state_d = RECOVER;
            end
            RD_SETUP: begin
                // Counter runs from RD_CLK entry so sampling lands EN+10 edges after CLK rises.
                wait_d  = WCW'(act_q) + WCW'(RD_EVAL_CYCLES);
                ph_d    = '0;
                state_d = RD_CLK;
            end
            RD_CLK: begin
                wait_d = wait_q - 1'b1;
                if (ph_q == CLK_LAST) state_d = RD_WAIT;
                else                  ph_d    = ph_q + 1'b1;
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    qs_d    = sram_q_i;
                    flag_d  = sram_flag_i;
                    ph_d    = '0;
                    state_d = RECOVER;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RECOVER: begin
                if (ph_q != REC_LAST) begin
                    ph_d = ph_q + 1'b1;
                end else if (!we_q && flag_q && (retry_q < MAXR)) begin
                    retry_d = retry_q + 1'b1;
                    act_d   = cfg_en_boost_i;
                    boost_d = 1'b1;
                    state_d = RD_SETUP;
                end else begin
                    rvalid_d = 1'b1;
                    err_d    = !we_q && flag_q;
                    if (!we_q) rdata_d = qs_q;
                    boost_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_RBL or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            act_q    <= '0;
            mode_q   <= 1'b0;
            retry_q  <= '0;
            wait_q   <= '0;
            ph_q     <= '0;
            boost_q  <= 1'b0;
            qs_q     <= '0;
            flag_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            act_q    <= act_d;
            mode_q   <= mode_d;
            retry_q  <= retry_d;
            wait_q   <= wait_d;
            ph_q     <= ph_d;
            boost_q  <= boost_d;
            qs_q     <= qs_d;
            flag_q   <= flag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Macro strobes are registered from the current state, so they trail it by one edge.
    always_ff @(posedge CLK_RBL or negedge rst_n) begin
        if (!rst_n) begin
            cen_q <= 1'b1;
            wen_q <= 1'b1;
            clk_q <= 1'b0;
            brs_q <= '0;
            en_q  <= '0;
            d_q   <= '0;
        end else begin
            cen_q <= !(state_q inside {WR_SETUP, WR_CLK, RD_SETUP, RD_CLK, RD_WAIT});
            wen_q <= !(state_q inside {WR_SETUP, WR_CLK});
            clk_q <= state_q inside {WR_CLK, RD_CLK};
            brs_q <= (state_q inside {WR_SETUP, WR_CLK, RD_SETUP, RD_CLK, RD_WAIT}) ? addr_q : '0;
            en_q  <= (state_q inside {RD_SETUP, RD_CLK, RD_WAIT}) ? act_q : '0;
            d_q   <= (state_q inside {WR_SETUP, WR_CLK}) ? wdata_q : '0;
        end
    end

    ssram_wl_dec u_wl_dec (
        .CLK_RBL (CLK_RBL),
        .rst_n   (rst_n),
        .load_i  (grant),
        .addr_i  (addr_i),
        .wl_o    (sram_wl_o)
    );

    assign sram_cen_o      = cen_q;
    assign sram_wen_o      = wen_q;
    assign sram_clk_o      = clk_q;
    assign sram_brs_o      = brs_q;
    assign sram_en_o       = {7'b0, en_q};
    assign sram_mode_o     = mode_q;
    assign sram_boost_en_o = boost_q;
    assign sram_d_o        = d_q;
    assign rvalid_o        = rvalid_q;
    assign rdata_o         = rdata_q;
    assign err_o           = err_q;
endmodule

// File: tb/tb_ssram_ctrl.sv
// Directed bench for ssram_ctrl with a small behavioural macro model driving Q/FLAG.
module tb_ssram_ctrl;
    logic         CLK_RBL = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_i = 1'b0, we_i = 1'b0, cfg_mode_i = 1'b0;
    logic [7:0]   addr_i = '0;
    logic [31:0]  wdata_i = '0;
    logic [4:0]   cfg_en_i = '0, cfg_en_boost_i = '0;
    logic         gnt_o, rvalid_o, err_o;
    logic [31:0]  rdata_o;
    logic         sram_cen_o, sram_wen_o, sram_clk_o, sram_mode_o, sram_boost_en_o;
    logic [7:0]   sram_brs_o;
    logic [255:0] sram_wl_o;
    logic [11:0]  sram_en_o;
    logic [31:0]  sram_d_o;
    logic [31:0]  sram_q_i = '0;
    logic         sram_flag_i = 1'b0;

    int nvec = 0, nbad = 0;

    ssram_ctrl #(.MAX_RETRY(2)) dut (
        .CLK_RBL(CLK_RBL), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .cfg_en_i(cfg_en_i), .cfg_en_boost_i(cfg_en_boost_i),
        .cfg_mode_i(cfg_mode_i), .sram_cen_o(sram_cen_o), .sram_wen_o(sram_wen_o),
        .sram_clk_o(sram_clk_o), .sram_brs_o(sram_brs_o), .sram_wl_o(sram_wl_o),
        .sram_en_o(sram_en_o), .sram_mode_o(sram_mode_o), .sram_boost_en_o(sram_boost_en_o),
        .sram_d_o(sram_d_o), .sram_q_i(sram_q_i), .sram_flag_i(sram_flag_i)
    );

    always #5 CLK_RBL = ~CLK_RBL;

    // Macro model: flags reads numbered [flag_start, flag_start+flag_num), corrupting Q to ~data.
    logic [31:0] mem [256];
    int          rd_total = 0, pulses = 0, flag_start = 0, flag_num = 0;
    logic        nb_cen, nb_wen, pl_cen, pl_wen;
    logic [31:0] nb_d, pl_d;
    logic        boost_at [64];
    logic [11:0] en_at [64];

    always @(negedge CLK_RBL) begin
        nb_cen = sram_cen_o; nb_wen = sram_wen_o; nb_d = sram_d_o;
    end

    always @(posedge sram_clk_o) begin : macro_model
        int  a;
        logic fl;
        a = 0;
        for (int i = 0; i < 256; i++) if (sram_wl_o[i]) a = i;
        pulses++;
        pl_cen = nb_cen; pl_wen = nb_wen; pl_d = nb_d;
        if (!sram_cen_o) begin
            if (!sram_wen_o) mem[a] = sram_d_o;
            else begin
                boost_at[rd_total % 64] = sram_boost_en_o;
                en_at[rd_total % 64]    = sram_en_o;
                fl = ((rd_total - flag_start) < flag_num);
                sram_flag_i = fl;
                sram_q_i    = fl ? ~mem[a] : mem[a];
                rd_total++;
            end
        end
    end

    // Protocol monitor: CEN high gaps, grant legality, completion/grant overlap.
    int   hi_run = 0, short_gaps = 0, gnt_bad = 0, gnt_cnt = 0, rv_cnt = 0, rv_gnt = 0;
    logic seen_low = 1'b0, prev_gnt = 1'b0;
    always @(negedge CLK_RBL) begin
        if (rst_n) begin
            if (sram_cen_o) hi_run++;
            else begin
                if (seen_low && hi_run == 1) short_gaps++;
                hi_run = 0; seen_low = 1'b1;
            end
            if (gnt_o && (!sram_cen_o || prev_gnt)) gnt_bad++;
            if (gnt_o) gnt_cnt++;
            if (rvalid_o) rv_cnt++;
            if (rvalid_o && gnt_o) rv_gnt++;
            prev_gnt = gnt_o;
        end else begin
            seen_low = 1'b0; hi_run = 0; prev_gnt = 1'b0;
        end
    end

    task automatic do_op(input logic we, input logic [7:0] a, input logic [31:0] wd,
                         input logic [4:0] en, input logic [4:0] ben, input logic md,
                         output logic g, output int lat, output logic [31:0] rd,
                         output logic er, output logic mo);
        @(posedge CLK_RBL); #1;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        cfg_en_i = en; cfg_en_boost_i = ben; cfg_mode_i = md;
        @(negedge CLK_RBL); g = gnt_o;
        @(posedge CLK_RBL); #1;
        req_i = 1'b0; cfg_en_i = 5'd31; cfg_mode_i = ~md; wdata_i = ~wd;
        lat = 0;
        @(negedge CLK_RBL);
        while (!rvalid_o && lat < 400) begin @(negedge CLK_RBL); lat++; end
        rd = rdata_o; er = err_o; mo = sram_mode_o;
    endtask

    task automatic test_reset;
        #12;
        nvec++; if ({sram_cen_o, sram_wen_o, sram_clk_o} !== 3'b110) begin nbad++;
            $display("FAIL reset_strobes: got %b expected 110", {sram_cen_o, sram_wen_o, sram_clk_o}); end
        nvec++; if ({sram_brs_o, sram_en_o, sram_d_o} !== 52'd0) begin nbad++;
            $display("FAIL reset_brs_en_d: got %0h expected 0", {sram_brs_o, sram_en_o, sram_d_o}); end
        nvec++; if (sram_wl_o !== 256'd0) begin nbad++;
            $display("FAIL reset_wl: got %0h expected 0", sram_wl_o); end
        nvec++; if ({sram_mode_o, sram_boost_en_o, gnt_o} !== 3'b000) begin nbad++;
            $display("FAIL reset_mode_boost_gnt: got %b expected 000", {sram_mode_o, sram_boost_en_o, gnt_o}); end
        nvec++; if ({rvalid_o, err_o, rdata_o} !== 34'd0) begin nbad++;
            $display("FAIL reset_resp: got %0h expected 0", {rvalid_o, err_o, rdata_o}); end
        @(negedge CLK_RBL); rst_n = 1'b1;
    endtask

    task automatic test_write;
        logic g, er, mo; int lat, p0; logic [31:0] rd;
        p0 = pulses;
        do_op(1'b1, 8'h12, 32'hDEADBEEF, 5'd3, 5'd0, 1'b0, g, lat, rd, er, mo);
        nvec++; if (g !== 1'b1) begin nbad++; $display("FAIL wr_gnt: got %b expected 1", g); end
        nvec++; if (lat !== 4) begin nbad++; $display("FAIL wr_latency: got %0d expected 4", lat); end
        nvec++; if (pulses - p0 !== 1) begin nbad++; $display("FAIL wr_pulses: got %0d expected 1", pulses - p0); end
        nvec++; if ({pl_cen, pl_wen} !== 2'b00) begin nbad++;
            $display("FAIL wr_setup_strobes: got %b expected 00", {pl_cen, pl_wen}); end
        nvec++; if (pl_d !== 32'hDEADBEEF) begin nbad++; $display("FAIL wr_setup_d: got %h expected deadbeef", pl_d); end
        nvec++; if (er !== 1'b0) begin nbad++; $display("FAIL wr_err: got %b expected 0", er); end
        @(negedge CLK_RBL);
        nvec++; if (rvalid_o !== 1'b0) begin nbad++; $display("FAIL wr_rvalid_pulse: got %b expected 0", rvalid_o); end
    endtask

    task automatic test_read;
        logic g, er, mo; int lat, r0; logic [31:0] rd; logic [255:0] wl_exp;
        wl_exp = 256'd1 << 18;
        r0 = rd_total;
        do_op(1'b0, 8'h12, 32'h0, 5'd3, 5'd0, 1'b1, g, lat, rd, er, mo);
        nvec++; if (lat !== 17) begin nbad++; $display("FAIL rd_latency: got %0d expected 17", lat); end
        nvec++; if (rd !== 32'hDEADBEEF) begin nbad++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        nvec++; if (er !== 1'b0) begin nbad++; $display("FAIL rd_err: got %b expected 0", er); end
        nvec++; if (sram_wl_o !== wl_exp) begin nbad++; $display("FAIL rd_wl_onehot: got %h expected %h", sram_wl_o, wl_exp); end
        nvec++; if (en_at[r0 % 64] !== 12'd3) begin nbad++; $display("FAIL rd_en_count: got %0d expected 3", en_at[r0 % 64]); end
        nvec++; if (mo !== 1'b1) begin nbad++; $display("FAIL rd_mode: got %b expected 1", mo); end
        nvec++; if (rd_total - r0 !== 1) begin nbad++; $display("FAIL rd_reads: got %0d expected 1", rd_total - r0); end
        do_op(1'b0, 8'h12, 32'h0, 5'd0, 5'd0, 1'b0, g, lat, rd, er, mo);
        nvec++; if (lat !== 14) begin nbad++; $display("FAIL rd_en0_latency: got %0d expected 14", lat); end
        nvec++; if (rd !== 32'hDEADBEEF) begin nbad++; $display("FAIL rd_en0_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_retry_once;
        logic g, er, mo; int lat, r0; logic [31:0] rd;
        do_op(1'b1, 8'h40, 32'h0BADF00D, 5'd2, 5'd0, 1'b0, g, lat, rd, er, mo);
        r0 = rd_total; flag_start = r0; flag_num = 1;
        do_op(1'b0, 8'h40, 32'h0, 5'd3, 5'd6, 1'b0, g, lat, rd, er, mo);
        nvec++; if (rd_total - r0 !== 2) begin nbad++; $display("FAIL rt1_reads: got %0d expected 2", rd_total - r0); end
        nvec++; if (boost_at[r0 % 64] !== 1'b0) begin nbad++; $display("FAIL rt1_boost_first: got %b expected 0", boost_at[r0 % 64]); end
        nvec++; if (boost_at[(r0 + 1) % 64] !== 1'b1) begin nbad++;
            $display("FAIL rt1_boost_retry: got %b expected 1", boost_at[(r0 + 1) % 64]); end
        nvec++; if (en_at[(r0 + 1) % 64] !== 12'd6) begin nbad++;
            $display("FAIL rt1_en_retry: got %0d expected 6", en_at[(r0 + 1) % 64]); end
        nvec++; if ({er, rd} !== {1'b0, 32'h0BADF00D}) begin nbad++;
            $display("FAIL rt1_resp: got err=%b data=%h expected err=0 data=0badf00d", er, rd); end
        nvec++; if (sram_boost_en_o !== 1'b0) begin nbad++; $display("FAIL rt1_boost_idle: got %b expected 0", sram_boost_en_o); end
        flag_num = 0;
    endtask

    task automatic test_retry_exhaust;
        logic g, er, mo; int lat, r0; logic [31:0] rd;
        r0 = rd_total; flag_start = r0; flag_num = 100;
        do_op(1'b0, 8'h40, 32'h0, 5'd2, 5'd4, 1'b0, g, lat, rd, er, mo);
        flag_num = 0;
        nvec++; if (rd_total - r0 !== 3) begin nbad++; $display("FAIL rtx_reads: got %0d expected 3", rd_total - r0); end
        nvec++; if (er !== 1'b1) begin nbad++; $display("FAIL rtx_err: got %b expected 1", er); end
        nvec++; if (rd !== 32'hF4520FF2) begin nbad++; $display("FAIL rtx_last_q: got %h expected f4520ff2", rd); end
        nvec++; if (en_at[(r0 + 2) % 64] !== 12'd4) begin nbad++;
            $display("FAIL rtx_en_retry2: got %0d expected 4", en_at[(r0 + 2) % 64]); end
    endtask

    task automatic test_reset_midop;
        logic g, er, mo; int lat, rv0; logic [31:0] rd;
        @(posedge CLK_RBL); #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h12; cfg_en_i = 5'd3;
        @(posedge CLK_RBL); #1; req_i = 1'b0;
        repeat (3) @(posedge CLK_RBL);
        #3;
        nvec++; if ({sram_cen_o, sram_clk_o} !== 2'b01) begin nbad++;
            $display("FAIL mr_pre_state: got %b expected 01", {sram_cen_o, sram_clk_o}); end
        rst_n = 1'b0; #1;
        nvec++; if ({sram_cen_o, sram_clk_o, rvalid_o} !== 3'b100) begin nbad++;
            $display("FAIL mr_forced: got %b expected 100", {sram_cen_o, sram_clk_o, rvalid_o}); end
        nvec++; if (sram_wl_o !== 256'd0) begin nbad++; $display("FAIL mr_wl_clear: got %h expected 0", sram_wl_o); end
        repeat (3) @(negedge CLK_RBL);
        rst_n = 1'b1; rv0 = rv_cnt;
        repeat (25) @(negedge CLK_RBL);
        nvec++; if (rv_cnt !== rv0) begin nbad++; $display("FAIL mr_no_rvalid: got %0d pulses expected 0", rv_cnt - rv0); end
        do_op(1'b1, 8'h33, 32'h55AA1234, 5'd1, 5'd0, 1'b0, g, lat, rd, er, mo);
        do_op(1'b0, 8'h33, 32'h0, 5'd2, 5'd0, 1'b0, g, lat, rd, er, mo);
        nvec++; if (lat !== 16) begin nbad++; $display("FAIL mr_after_latency: got %0d expected 16", lat); end
        nvec++; if ({er, rd} !== {1'b0, 32'h55AA1234}) begin nbad++;
            $display("FAIL mr_after_resp: got err=%b data=%h expected err=0 data=55aa1234", er, rd); end
    endtask

    task automatic test_back_to_back;
        logic        op_we [4];
        logic [7:0]  op_a  [4];
        logic [31:0] op_d  [4];
        int k, c, cyc, g0, gb0, sg0, rg0;
        logic granted;
        op_we = '{1'b1, 1'b0, 1'b1, 1'b0};
        op_a  = '{8'h20, 8'h20, 8'h21, 8'h21};
        op_d  = '{32'h11111111, 32'h0, 32'h22222222, 32'h0};
        g0 = gnt_cnt; gb0 = gnt_bad; sg0 = short_gaps; rg0 = rv_gnt;
        k = 0; c = 0; cyc = 0;
        @(posedge CLK_RBL); #1;
        req_i = 1'b1; we_i = op_we[0]; addr_i = op_a[0]; wdata_i = op_d[0]; cfg_en_i = 5'd1;
        while (c < 4 && cyc < 400) begin
            @(negedge CLK_RBL);
            if (rvalid_o) begin
                if (!op_we[c]) begin
                    nvec++; if (rdata_o !== mem[op_a[c]]) begin nbad++;
                        $display("FAIL b2b_rdata%0d: got %h expected %h", c, rdata_o, op_d[c - 1]); end
                    nvec++; if (rdata_o !== op_d[c - 1]) begin nbad++;
                        $display("FAIL b2b_rdata_vs_write%0d: got %h expected %h", c, rdata_o, op_d[c - 1]); end
                end
                c++;
            end
            granted = gnt_o;
            @(posedge CLK_RBL); #1;
            if (granted) begin
                k++;
                if (k < 4) begin we_i = op_we[k]; addr_i = op_a[k]; wdata_i = op_d[k]; end
                else req_i = 1'b0;
            end
            cyc++;
        end
        req_i = 1'b0;
        nvec++; if (c !== 4) begin nbad++; $display("FAIL b2b_completions: got %0d expected 4", c); end
        nvec++; if (gnt_cnt - g0 !== 4) begin nbad++; $display("FAIL b2b_grants: got %0d expected 4", gnt_cnt - g0); end
        nvec++; if (gnt_bad - gb0 !== 0) begin nbad++; $display("FAIL b2b_gnt_not_idle: got %0d expected 0", gnt_bad - gb0); end
        nvec++; if (short_gaps - sg0 !== 0) begin nbad++; $display("FAIL b2b_recover_gap: got %0d expected 0", short_gaps - sg0); end
        nvec++; if (rv_gnt - rg0 !== 3) begin nbad++; $display("FAIL b2b_gnt_with_rvalid: got %0d expected 3", rv_gnt - rg0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_retry_once();
        test_retry_exhaust();
        test_reset_midop();
        test_back_to_back();
        repeat (3) @(negedge CLK_RBL);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
